// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two ALU clients and alu_arbiter.
// Width N must match the arbiter instance.
interface alu_arbiter_if #(parameter int N = 8);
  logic [1:0]   i_req_valid;
  logic [1:0]   o_req_ready;
  logic [N-1:0] i_a0, i_b0, i_a1, i_b1;
  logic [1:0]   i_ctrl0, i_ctrl1;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic         o_rsp_id;
  logic [N-1:0] o_rsp_result;
  logic         o_rsp_carry;
  logic         o_busy;

  modport slave (
    input  i_req_valid, i_a0, i_b0, i_ctrl0, i_a1, i_b1, i_ctrl1, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_carry, o_busy
  );

  modport master (
    output i_req_valid, i_a0, i_b0, i_ctrl0, i_a1, i_b1, i_ctrl1, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_carry, o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-client arbiter in front of a single N-bit add/sub/and/or ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module alu #(parameter int N = 8) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   ctrl,
  output logic [N-1:0] result,
  output logic         carry
);
  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  // Adder always runs so logic ops still report its carry.
  assign b_eff = ctrl[0] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, ctrl[0]};
  assign carry = sum[N];

  always_comb begin
    result = sum[N-1:0];
    case (ctrl)
      2'b10:   result = a & b;
      2'b11:   result = a | b;
      default: result = sum[N-1:0];
    endcase
  end
endmodule

module alu_arbiter #(parameter int N = 8) (
  input logic           i_clk,
  input logic           i_rst,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic [N-1:0] op_a, op_b;
  logic [1:0]   op_ctrl;
  logic         op_id;
  logic         rsp_valid, rsp_id, rsp_carry, busy;
  logic [N-1:0] rsp_result;
  logic [N-1:0] alu_res;
  logic         alu_cy;
  logic         gnt;
  logic         accept;

`ifdef ALU_ARB_RR_EN
  logic last_gnt;

  always_comb begin
    gnt = bus.i_req_valid[1];
    if (&bus.i_req_valid) gnt = ~last_gnt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt;
  end
`else
  always_comb gnt = ~bus.i_req_valid[0];
`endif

  // Ready depends only on state, valids and grant history.
  assign accept          = (state == IDLE) && (|bus.i_req_valid);
  assign bus.o_req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  alu #(.N(N)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .ctrl   (op_ctrl),
    .result (alu_res),
    .carry  (alu_cy)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a    <= gnt ? bus.i_a1    : bus.i_a0;
          op_b    <= gnt ? bus.i_b1    : bus.i_b0;
          op_ctrl <= gnt ? bus.i_ctrl1 : bus.i_ctrl0;
          op_id   <= gnt;
          busy    <= 1'b1;
          state   <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_res;
          rsp_carry  <= alu_cy;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (bus.i_rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_id     = rsp_id;
  assign bus.o_rsp_result = rsp_result;
  assign bus.o_rsp_carry  = rsp_carry;
  assign bus.o_busy       = busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus handshake corner sequences.
module tb_alu_arbiter;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  alu_arbiter_if #(.N(8)) bus ();
  alu_arbiter #(.N(8)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  typedef struct {
    logic       id;
    logic [7:0] a, b;
    logic [1:0] ctrl;
    logic [7:0] res;
    logic       cy;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       cy;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, b, input logic [1:0] c);
    logic [8:0] s;
    s = (c[0] == 1'b0) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} + {1'b0, ~b} + 9'd1);
    case (c)
      2'b10:   model = {s[8], a & b};
      2'b11:   model = {s[8], a | b};
      default: model = s;
    endcase
  endfunction

  task automatic collect();
    exp_t e;
    int   n = 0;
    while (!bus.o_rsp_valid && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.o_rsp_valid) chk("rsp_timeout", 0, 1);
    else if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("rsp_id", bus.o_rsp_id, e.id);
      chk("rsp_result", bus.o_rsp_result, e.res);
      chk("rsp_carry", bus.o_rsp_carry, e.cy);
    end
  endtask

  task automatic drive_ops(input logic id, input logic [7:0] a, b, input logic [1:0] c);
    bus.i_a0 = id ? 8'($urandom) : a;
    bus.i_b0 = id ? 8'($urandom) : b;
    bus.i_ctrl0 = id ? 2'($urandom) : c;
    bus.i_a1 = id ? a : 8'($urandom);
    bus.i_b1 = id ? b : 8'($urandom);
    bus.i_ctrl1 = id ? c : 2'($urandom);
  endtask

  // Full single transaction with exact-latency checks; starts and ends in IDLE.
  task automatic send(input vec_t v);
    sb.push_back('{v.id, v.res, v.cy});
    @(negedge i_clk);
    drive_ops(v.id, v.a, v.b, v.ctrl);
    bus.i_req_valid = v.id ? 2'b10 : 2'b01;
    #1 chk("req_ready", bus.o_req_ready, v.id ? 2'b10 : 2'b01);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    chk("exec_rsp_valid", bus.o_rsp_valid, 0);
    chk("exec_busy", bus.o_busy, 1);
    @(negedge i_clk);
    chk("latency_rsp_valid", bus.o_rsp_valid, 1);
    collect();
  endtask

  vec_t tbl[8];
  initial begin
    logic [8:0] m;
    vec_t       v;
    int         got;
    logic       bad;
    logic [7:0] held_res;

    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 1'b1;
    drive_ops(1'b0, 8'h00, 8'h00, 2'b00);

    tbl[0] = '{1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'hBD, 8'hA5, 2'b00, 8'h62, 1'b1};
    tbl[2] = '{1'b1, 8'hBD, 8'hA5, 2'b01, 8'h18, 1'b1};
    tbl[3] = '{1'b0, 8'hBD, 8'hA5, 2'b10, 8'hA5, 1'b1};
    tbl[4] = '{1'b0, 8'hBD, 8'hA5, 2'b11, 8'hBD, 1'b1};
    tbl[5] = '{1'b1, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 8'h01, 2'b01, 8'hFF, 1'b0};
    tbl[7] = '{1'b1, 8'hF0, 8'h0F, 2'b10, 8'h00, 1'b0};

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_result", bus.o_rsp_result, 0);
    chk("rst_carry", bus.o_rsp_carry, 0);
    chk("rst_id", bus.o_rsp_id, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_req_ready", bus.o_req_ready, 0);

    for (int i = 0; i < 8; i++) send(tbl[i]);

    // Random ops, alternating requesters, ending on requester 1.
    for (int i = 0; i < 4; i++) begin
      v.id = 1'(i % 2);
      v.a = 8'($urandom); v.b = 8'($urandom); v.ctrl = 2'($urandom);
      m = model(v.a, v.b, v.ctrl);
      v.res = m[7:0]; v.cy = m[8];
      send(v);
    end

    // Contest: both held valid for three operations.
    @(negedge i_clk);
    bus.i_a0 = 8'h11; bus.i_b0 = 8'h22; bus.i_ctrl0 = 2'b00;
    bus.i_a1 = 8'h40; bus.i_b1 = 8'h50; bus.i_ctrl1 = 2'b11;
`ifdef ALU_ARB_RR_EN
    sb.push_back('{1'b0, 8'h33, 1'b0});
    sb.push_back('{1'b1, 8'h50, 1'b0});
    sb.push_back('{1'b0, 8'h33, 1'b0});
`else
    repeat (3) sb.push_back('{1'b0, 8'h33, 1'b0});
`endif
    bus.i_req_valid = 2'b11;
    got = 0;
    bad = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      #1 if (bus.o_req_ready == 2'b11) bad = 1'b1;
      @(negedge i_clk);
      if (bus.o_rsp_valid) begin
        collect();
        got++;
        if (got == 3) bus.i_req_valid = 2'b00;
      end
    end
    chk("contest_count", got, 3);
    chk("contest_onehot", bad, 0);

    // Response stall: outputs hold, no accepts while requester 1 waits.
    @(negedge i_clk);
    bus.i_rsp_ready = 1'b0;
    sb.push_back('{1'b0, 8'h0E, 1'b1});
    drive_ops(1'b0, 8'h0F, 8'h01, 2'b01);
    bus.i_req_valid = 2'b01;
    @(negedge i_clk);
    bus.i_req_valid = 2'b10;
    @(negedge i_clk);
    chk("stall_rsp_valid", bus.o_rsp_valid, 1);
    held_res = bus.o_rsp_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("stall_valid", bus.o_rsp_valid, 1);
      chk("stall_result", bus.o_rsp_result, held_res);
      chk("stall_ready", bus.o_req_ready, 0);
      chk("stall_busy", bus.o_busy, 1);
    end
    collect();
    bus.i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("post_hs_valid", bus.o_rsp_valid, 0);
    chk("post_hs_busy", bus.o_busy, 0);
    chk("post_hs_ready", bus.o_req_ready, 2'b10);
    bus.i_req_valid = 2'b00;
    #1 chk("drop_ready", bus.o_req_ready, 0);

    // Reset while in EXEC discards the operation.
    @(negedge i_clk);
    drive_ops(1'b0, 8'h80, 8'h80, 2'b00);
    bus.i_req_valid = 2'b01;
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    chk("pre_rst_busy", bus.o_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("exec_rst_valid", bus.o_rsp_valid, 0);
    chk("exec_rst_result", bus.o_rsp_result, 0);
    chk("exec_rst_carry", bus.o_rsp_carry, 0);
    chk("exec_rst_id", bus.o_rsp_id, 0);
    chk("exec_rst_busy", bus.o_busy, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("no_rsp_after_rst", bus.o_rsp_valid, 0);
    end

    // First contest after reset goes to requester 0.
    sb.push_back('{1'b0, 8'h33, 1'b0});
    bus.i_a0 = 8'h11; bus.i_b0 = 8'h22; bus.i_ctrl0 = 2'b00;
    bus.i_a1 = 8'h40; bus.i_b1 = 8'h50; bus.i_ctrl1 = 2'b11;
    bus.i_req_valid = 2'b11;
    #1 chk("rst_contest_ready", bus.o_req_ready, 2'b01);
    @(negedge i_clk);
    bus.i_req_valid = 2'b00;
    @(negedge i_clk);
    chk("rst_contest_lat", bus.o_rsp_valid, 1);
    collect();
    @(negedge i_clk);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
